// File: rtl/sd_pkg.sv
// sd_pkg: shared SD definitions (arbiter states, card types, command indices)
package sd_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWNED, ARB_DRAIN, ARB_GAP} arb_state_t;
  typedef enum logic [1:0] {CARD_NONE, CARD_SDSC, CARD_SDHC} card_type_t;
  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD16  = 6'd16;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD24  = 6'd24;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] CMD58  = 6'd58;
endpackage

// File: rtl/sd_cmd_arbiter_if.sv
// sd_cmd_arbiter_if: link between the arbiter and the SD command engine
interface sd_cmd_arbiter_if;
  logic        start;
  logic [15:0] precnt;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic [15:0] clkdiv;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        syntaxe;
  logic [31:0] resparg;
  modport master (output start, precnt, cmd, arg, clkdiv, input busy, done, timeout, syntaxe, resparg);
  modport slave  (input start, precnt, cmd, arg, clkdiv, output busy, done, timeout, syntaxe, resparg);
endinterface

// File: rtl/sd_rr_pick.sv
// sd_rr_pick: 2-way round-robin winner; on contention the port that did not own last wins
module sd_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);
  assign win = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter: round-robin lock arbiter sharing one SD command engine between two sequencers.
// Optional lock watchdog enabled by defining SD_ARB_WATCHDOG_EN.
module sd_cmd_arbiter
  import sd_pkg::*;
#(
  parameter logic [15:0] RST_CLKDIV = 16'd192,
  parameter logic [31:0] WDT_CYCLES = 32'd4_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  lock_req,
  output logic [1:0]  grant,
  input  logic        r0_start,
  input  logic [15:0] r0_precnt,
  input  logic [5:0]  r0_cmd,
  input  logic [31:0] r0_arg,
  input  logic [15:0] r0_clkdiv,
  output logic        r0_busy,
  output logic        r0_done,
  input  logic        r1_start,
  input  logic [15:0] r1_precnt,
  input  logic [5:0]  r1_cmd,
  input  logic [31:0] r1_arg,
  input  logic [15:0] r1_clkdiv,
  output logic        r1_busy,
  output logic        r1_done,
  output logic        rsp_timeout,
  output logic        rsp_syntaxe,
  output logic [31:0] rsp_arg,
  sd_cmd_arbiter_if.master eng,
  output logic        proto_err,
  output logic        wdt_fire
);
  arb_state_t state, nxt;
  logic       last_owner, launch_port;
  logic       owned, own_start, other_start, acc, err, fire;
  logic [1:0] req_ok, win;

  sd_rr_pick u_pick (.req(req_ok), .last(last_owner), .win(win));

  // last_owner doubles as the current owner while OWNED
  assign owned       = (state == ARB_OWNED);
  assign grant       = owned ? (last_owner ? 2'b10 : 2'b01) : 2'b00;
  assign own_start   = last_owner ? r1_start : r0_start;
  assign other_start = last_owner ? r0_start : r1_start;
  assign acc         = owned && own_start && !eng.busy && !eng.start;
  assign err         = owned ? (other_start || (own_start && !acc)) : (r0_start || r1_start);
  assign r0_busy     = grant[0] ? eng.busy : 1'b1;
  assign r1_busy     = grant[1] ? eng.busy : 1'b1;
  assign r0_done     = eng.done && !launch_port;
  assign r1_done     = eng.done && launch_port;
  assign rsp_timeout = eng.timeout;
  assign rsp_syntaxe = eng.syntaxe;
  assign rsp_arg     = eng.resparg;

`ifdef SD_ARB_WATCHDOG_EN
  logic [31:0] wdt_cnt;
  logic [1:0]  blk;
  logic        counting;
  assign counting = owned && !eng.busy && !eng.start;
  assign fire     = counting && !acc && (wdt_cnt == WDT_CYCLES - 32'd1);
  // a port released by the watchdog must drop its request before it can win again
  assign req_ok   = lock_req & ~blk;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wdt_cnt  <= '0;
      blk      <= '0;
      wdt_fire <= 1'b0;
    end else begin
      wdt_cnt  <= (acc || !owned) ? 32'd0 : counting ? wdt_cnt + 32'd1 : wdt_cnt;
      blk      <= (blk & lock_req) | (fire ? grant : 2'b00);
      wdt_fire <= fire;
    end
`else
  assign fire     = 1'b0;
  assign req_ok   = lock_req;
  assign wdt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= ARB_IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      ARB_IDLE:  nxt = |req_ok ? ARB_OWNED : ARB_IDLE;
      ARB_OWNED: nxt = (!lock_req[last_owner] || fire) ? ARB_DRAIN : ARB_OWNED;
      ARB_DRAIN: nxt = (!eng.busy && !eng.start) ? ARB_GAP : ARB_DRAIN;
      default:   nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      last_owner  <= 1'b1;
      launch_port <= 1'b0;
      eng.start   <= 1'b0;
      eng.precnt  <= '0;
      eng.cmd     <= '0;
      eng.arg     <= '0;
      eng.clkdiv  <= RST_CLKDIV;
      proto_err   <= 1'b0;
    end else begin
      if (state == ARB_IDLE && |req_ok) last_owner <= win[1];
      if (acc) begin
        launch_port <= last_owner;
        eng.precnt  <= last_owner ? r1_precnt : r0_precnt;
        eng.cmd     <= last_owner ? r1_cmd : r0_cmd;
        eng.arg     <= last_owner ? r1_arg : r0_arg;
      end
      if (owned && !eng.busy) eng.clkdiv <= last_owner ? r1_clkdiv : r0_clkdiv;
      eng.start <= acc;
      proto_err <= err;
    end
endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// tb_sd_cmd_arbiter: directed self-checking bench for sd_cmd_arbiter
module tb_sd_cmd_arbiter;
  logic        clk = 1'b0, rstn = 1'b0;
  logic [1:0]  lock_req = '0, grant;
  logic        r0_start = 0, r1_start = 0, r0_busy, r1_busy, r0_done, r1_done;
  logic [15:0] r0_precnt = '0, r1_precnt = '0, r0_clkdiv = 16'd4, r1_clkdiv = 16'd8;
  logic [5:0]  r0_cmd = '0, r1_cmd = '0;
  logic [31:0] r0_arg = '0, r1_arg = '0, rsp_arg;
  logic        rsp_timeout, rsp_syntaxe, proto_err, wdt_fire;
  int          total = 0, bad = 0;

  sd_cmd_arbiter_if e ();

  sd_cmd_arbiter #(.RST_CLKDIV(16'd192), .WDT_CYCLES(32'd100)) dut (
    .clk(clk), .rstn(rstn), .lock_req(lock_req), .grant(grant),
    .r0_start(r0_start), .r0_precnt(r0_precnt), .r0_cmd(r0_cmd), .r0_arg(r0_arg),
    .r0_clkdiv(r0_clkdiv), .r0_busy(r0_busy), .r0_done(r0_done),
    .r1_start(r1_start), .r1_precnt(r1_precnt), .r1_cmd(r1_cmd), .r1_arg(r1_arg),
    .r1_clkdiv(r1_clkdiv), .r1_busy(r1_busy), .r1_done(r1_done),
    .rsp_timeout(rsp_timeout), .rsp_syntaxe(rsp_syntaxe), .rsp_arg(rsp_arg),
    .eng(e.master), .proto_err(proto_err), .wdt_fire(wdt_fire)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    e.busy = 0; e.done = 0; e.timeout = 0; e.syntaxe = 0; e.resparg = '0;
    #12;
    chk("rst_clkdiv", e.clkdiv, 16'd192);
    chk("rst_grant", grant, 2'b00);
    chk("rst_start", e.start, 0);
    chk("rst_cmd", e.cmd, 0);
    chk("rst_proto_err", proto_err, 0);
    rstn = 1;
    tick();
    lock_req = 2'b01;
    tick();
    chk("grant_r0", grant, 2'b01);
    chk("busy_view_r0", r0_busy, 0);
    chk("busy_view_r1", r1_busy, 1);
    tick();
    chk("clkdiv_r0", e.clkdiv, 16'd4);
    rstn = 0;
    #1;
    chk("async_rst_grant", grant, 2'b00);
    chk("async_rst_clkdiv", e.clkdiv, 16'd192);
    lock_req = 2'b11;
    #2 rstn = 1;
    tick();
    chk("both_req_grant", grant, 2'b01);
    lock_req = 2'b10;
    tick(3);
    chk("handover_gap", grant, 2'b00);
    tick();
    chk("handover_grant", grant, 2'b10);
    tick();
    chk("clkdiv_r1", e.clkdiv, 16'd8);
    r1_cmd = 6'd24; r1_arg = 32'h0000_1000; r1_precnt = 16'h0050; r1_start = 1;
    tick();
    r1_start = 0;
    chk("launch_start", e.start, 1);
    chk("launch_cmd", e.cmd, 6'd24);
    chk("launch_arg", e.arg, 32'h0000_1000);
    chk("launch_precnt", e.precnt, 16'h0050);
    chk("launch_no_err", proto_err, 0);
    tick();
    chk("start_one_cycle", e.start, 0);
    e.busy = 1;
    #1;
    chk("busy_owner_r1", r1_busy, 1);
    chk("busy_nonowner_r0", r0_busy, 1);
    e.done = 1; e.resparg = 32'hABCD_0123; e.syntaxe = 1;
    #1;
    chk("done_r1", r1_done, 1);
    chk("done_not_r0", r0_done, 0);
    chk("rsp_arg", rsp_arg, 32'hABCD_0123);
    chk("rsp_syntaxe", rsp_syntaxe, 1);
    tick();
    e.done = 0; e.busy = 0; e.syntaxe = 0;
    r0_start = 1;
    tick();
    r0_start = 0;
    chk("nonowner_err", proto_err, 1);
    chk("nonowner_no_start", e.start, 0);
    tick();
    chk("err_pulse_end", proto_err, 0);
    e.busy = 1; r1_start = 1;
    tick();
    r1_start = 0;
    chk("busy_start_err", proto_err, 1);
    chk("busy_start_dropped", e.start, 0);
    e.busy = 0; r1_cmd = 6'd17; r1_start = 1; lock_req = 2'b01;
    tick();
    r1_start = 0;
    chk("pending_launch_start", e.start, 1);
    chk("pending_launch_cmd", e.cmd, 6'd17);
    chk("pending_launch_grant", grant, 2'b00);
    e.busy = 1;
    tick(4);
    chk("drain_holds", grant, 2'b00);
    e.done = 1;
    #1;
    chk("drain_done_r1", r1_done, 1);
    chk("drain_done_not_r0", r0_done, 0);
    tick();
    e.done = 0; e.busy = 0;
    tick(2);
    chk("drain_gap", grant, 2'b00);
    tick();
    chk("regrant_r0", grant, 2'b01);
    chk("clkdiv_kept", e.clkdiv, 16'd8);
    tick();
    chk("clkdiv_reload", e.clkdiv, 16'd4);
`ifdef SD_ARB_WATCHDOG_EN
    begin
      int k = 0;
      while (!wdt_fire && k < 300) begin
        tick();
        k++;
      end
      chk("wdt_fire", wdt_fire, 1);
      chk("wdt_grant", grant, 2'b00);
      tick(5);
      chk("wdt_no_regrant", grant, 2'b00);
    end
`else
    tick(120);
    chk("wdt_tied", wdt_fire, 0);
    chk("no_wdt_grant", grant, 2'b01);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sd_cmd_arbiter.md
# sd_cmd_arbiter

Shares the single SD command engine between two requesters: port 0 (init/read sequencer) and port 1 (sector write sequencer). Each requester takes a lock, issues any number of commands, then releases it. The arbiter grants round-robin, registers the command fields into the engine, and routes engine responses back to the lock owner only. It sits between the FAT32 read/write sequencers and the command engine.

## Interface
Parameters:
- RST_CLKDIV, 16'd192, engine clock divider driven from reset until the first owner programs one.
- WDT_CYCLES, 32'd4_000_000, lock-watchdog limit in clk cycles. Used only with SD_ARB_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- lock_req  in  2  per-requester lock request; level, held for the whole transaction
- grant  out  2  one-hot lock owner; 2'b00 when no owner
- r0_start / r1_start  in  1  one-cycle command launch from requester n
- r0_precnt / r1_precnt  in  16  command pre-count
- r0_cmd / r1_cmd  in  6  command index
- r0_arg / r1_arg  in  32  command argument
- r0_clkdiv / r1_clkdiv  in  16  requested SD clock divider
- r0_busy / r1_busy  out  1  engine busy as seen by requester n
- r0_done / r1_done  out  1  response-done pulse routed to requester n
- rsp_timeout  out  1  shared response flag, valid only with rN_done
- rsp_syntaxe  out  1  shared response flag, valid only with rN_done
- rsp_arg  out  32  shared response argument, valid only with rN_done
- start  out  1  engine start
- precnt  out  16  to engine
- cmd  out  6  to engine
- arg  out  32  to engine
- clkdiv  out  16  to engine
- busy  in  1  from engine
- done  in  1  from engine
- timeout  in  1  from engine
- syntaxe  in  1  from engine
- resparg  in  32  from engine
- proto_err  out  1  pulse: start from a non-owner, or start while the engine is busy
- wdt_fire  out  1  pulse: watchdog forced a release

## Operation
- State machine states:
  - IDLE: no owner.
  - OWNED: lock held.
  - DRAIN: owner dropped its lock; waiting for the engine to go quiet.
  - GAP: one dead cycle before the next grant.
- IDLE → OWNED when any lock_req bit is set.
  - Winner is round-robin against last_owner (reset value 1, so port 0 wins first).
  - If both request, the port that is not last_owner wins.
- OWNED:
  - Owner start with busy=0 and no launch already pending: register precnt/cmd/arg and pulse start one cycle later.
  - A non-owner start is dropped and pulses proto_err. So is an owner start while busy=1 or while a launch is pending.
- OWNED → DRAIN when the owner drops lock_req.
  - Pending-launch rule: if the owner's start and lock drop arrive in the same cycle, the command is still launched.
- DRAIN → GAP when busy=0 and no launch is pending. GAP → IDLE after one cycle.
- clkdiv output:
  - Loaded from the owner's rN_clkdiv only while OWNED and busy=0.
  - Keeps its value across ownership changes.
- Response routing:
  - rsp_timeout, rsp_syntaxe and rsp_arg are pass-through from the engine.
  - done is steered to the rN_done of the port that launched the command (latched at launch). It stays steered there even if ownership changes mid-command.
- Busy view: rN_busy = busy for the owner, and 1 for a non-owner.

## Timing
- Reset values:
  - grant, start, proto_err, wdt_fire = 0.
  - precnt, cmd, arg = 0.
  - clkdiv = RST_CLKDIV.
  - state = IDLE.
- Grant latency: lock_req rises in cycle t → grant valid at t+1, from IDLE only.
- Start latency: rN_start in cycle t → start=1 at t+1 for exactly one cycle.
- done path is combinational (0 cycles) from the engine to rN_done.
- Minimum handover: lock drop at t with the engine idle → DRAIN at t+1 → GAP at t+2 → IDLE at t+3 → new grant at t+4.
- rstn asserted mid-command: all outputs return to reset values immediately. The engine is reset by the same rstn.

## Configuration
- SD_ARB_WATCHDOG_EN defined:
  - A 32-bit counter runs while OWNED with busy=0 and no start issued. It clears on every launch.
  - At WDT_CYCLES the arbiter forces OWNED → DRAIN, drops grant, and pulses wdt_fire.
  - The owner must drop lock_req before it can be regranted.
- Not defined: no counter; wdt_fire is tied to 0.

## Structure
- Shared package sd_pkg holds:
  - state encodings ARB_IDLE/ARB_OWNED/ARB_DRAIN/ARB_GAP;
  - card-type and command-index constants shared with the read/write sequencers.
- One natural sub-module: sd_rr_pick, the 2-way round-robin selector (lock_req, last_owner → one-hot winner).

## Test plan
- Reset → clkdiv=192, grant=00, start=0; lock_req=01 → grant=01 next cycle.
- Both lock_req=11 from reset → grant=01. Port 0 releases → grant=10 exactly 4 cycles later.
- Owner r1 issues cmd=24, arg=0x00001000 → start pulse one cycle later with those fields. The engine's done reaches r1_done only, not r0_done.
- Non-owner r0_start while r1 owns → proto_err pulse; engine start stays 0.
- Owner drops lock while busy=1 → state stays DRAIN until busy=0. The done from that command still goes to the original owner.
- With SD_ARB_WATCHDOG_EN and WDT_CYCLES=100: owner idles 100 cycles → wdt_fire pulse, grant=00.
